arb_memory: RTL

//  Shared main memory plus memory bus for NPORTS cache clients, parameterised in width, depth and port count.

---
 rtl/arb_memory.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/arb_memory.sv
`default_nettype none
// ============================================================================
// Module   : arb_memory
// Purpose  : Shared main memory and memory bus for NPORTS cache clients.
//            Concurrent requests go through a round-robin arbiter, one
//            transaction at a time. A req/ack handshake and a programmable
//            access delay model main-memory latency.
// Ports    : clk      - single clock, all state updates on posedge
//            rst      - synchronous reset, active-high
//            req      - per-port request, held high until that port's ack
//            rdwt     - per-port operation, 0 = read, 1 = write
//            addr     - per-port address, port p at [p*ADDRESSBIT +: ADDRESSBIT]
//            dataIn   - per-port write data, port p at [p*WORDSIZE +: WORDSIZE]
//            dataOut  - per-port registered read data
//            ack      - per-port one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module arb_memory #(
    parameter int ADDRESSBIT  = 10,
    parameter int WORDSIZE    = 32,
    parameter int MEMSIZE     = 1024,
    parameter int NPORTS      = 2,
    parameter int DELAY_CYCLE = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            req,
    input  logic [NPORTS-1:0]            rdwt,
    input  logic [NPORTS*ADDRESSBIT-1:0] addr,
    input  logic [NPORTS*WORDSIZE-1:0]   dataIn,
    output logic [NPORTS*WORDSIZE-1:0]   dataOut,
    output logic [NPORTS-1:0]            ack
);

    localparam int c_PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int c_CW = $clog2(DELAY_CYCLE + 1);
    localparam int c_IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [ADDRESSBIT:0] c_MEMSIZE   = (ADDRESSBIT+1)'(MEMSIZE);
    localparam logic [c_PW-1:0]     c_LAST_INIT = c_PW'(NPORTS - 1);
    localparam logic [c_CW-1:0]     c_DELAY     = c_CW'(DELAY_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [c_CW-1:0]         cnt_q;
    logic [c_PW-1:0]         last_q;
    logic [c_PW-1:0]         gnt_q;
    logic [ADDRESSBIT-1:0]   addr_q;
    logic [WORDSIZE-1:0]     din_q;
    logic                    rdwt_q;
    logic [NPORTS-1:0]       ack_q;
    logic [WORDSIZE-1:0]     dout_q [NPORTS];

    logic [WORDSIZE-1:0]     mem [MEMSIZE];

    logic [c_PW-1:0]         grant_d;
    logic                    w_found;
    logic                    w_access;
    logic                    w_inrange;
    logic [c_IW-1:0]         w_midx;
    logic [WORDSIZE-1:0]     w_rdata;

    // Round-robin search: start one past the last winner and wrap, so the
    // most recently served port has the lowest priority.
    always_comb begin
        grant_d = last_q;
        w_found = 1'b0;
        for (int i = 1; i <= NPORTS; i++) begin
            logic [c_PW-1:0] idx;
            idx = c_PW'((int'(last_q) + i) % NPORTS);
            if (!w_found && req[idx]) begin
                grant_d = idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_access  = (state_q == S_BUSY) && (cnt_q == c_CW'(1));
    assign w_inrange = ({1'b0, addr_q} < c_MEMSIZE);
    assign w_midx    = addr_q[c_IW-1:0];
    // Out-of-range reads return zero instead of touching the array.
    assign w_rdata   = w_inrange ? mem[w_midx] : '0;

    // Memory array has no reset; a reset landing on the access edge
    // suppresses the write so an aborted transaction leaves memory intact.
    always_ff @(posedge clk) begin
        if (!rst && w_access && rdwt_q && w_inrange) begin
            mem[w_midx] <= din_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= c_LAST_INIT;
            gnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rdwt_q  <= 1'b0;
            ack_q   <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                dout_q[p] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= '0;
                    if (w_found) begin
                        gnt_q   <= grant_d;
                        last_q  <= grant_d;
                        addr_q  <= addr[grant_d*ADDRESSBIT +: ADDRESSBIT];
                        din_q   <= dataIn[grant_d*WORDSIZE +: WORDSIZE];
                        rdwt_q  <= rdwt[grant_d];
                        cnt_q   <= c_DELAY;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - c_CW'(1);
                    if (w_access) begin
                        if (!rdwt_q) begin
                            dout_q[gnt_q] <= w_rdata;
                        end
                        ack_q[gnt_q] <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack = ack_q;

    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_dout
            assign dataOut[p*WORDSIZE +: WORDSIZE] = dout_q[p];
        end
    endgenerate

endmodule
`default_nettype wire
